line_cache_ctrl: RTL and testbench
==================================

// Module: line_cache_ctrl
// PURPOSE
//  Scheduler for the GBA line-buffer ring that sits between GBA capture (writer) and the HDMI image
//  generator (reader). Allocates the write bank, advances the read window on nextLine requests,
//  and publishes the prev/cur/next bank indices consumed by the 3x3 smoothing/grid datapath.
//  Drives sameLine so the scaler repeats a line instead of reading an unwritten bank.
//  Drives ready, which gates HDMI enable until the ring is primed after each newFrame.
// PARAMETERS
//  NUM_LINES    4    banks in ring; BW = $clog2(NUM_LINES)
//  PRIME_LINES  2    completed lines required before ready asserts (2..NUM_LINES-2)
//  GBA_LINES    160  lines per GBA frame
// PORTS
//  pxlClk       in   1   pixel clock; sole clock
//  rstN         in   1   asynchronous, active-low reset
//  newFrameIn   in   1   GBA frame start, level; rising edge detected internally
//  wrLineDone   in   1   1-cycle pulse: capture finished writing bank wrBank
//  nextLine     in   1   1-cycle pulse from image gen: advance to next GBA line
//  cacheUpdate  in   1   1-cycle pulse at cx==XStop: latch new read window
//  clrFlags     in   1   clears ovfl/undfl
//  wrBank       out  BW  bank capture writes into
//  rdPrevBank   out  BW  bank of line rdLine-1 (clamped to cur at line 0)
//  rdCurBank    out  BW  bank of line rdLine
//  rdNextBank   out  BW  bank of line rdLine+1 (clamped to cur at GBA_LINES-1)
//  rdLine       out  8   GBA line shown in current window
//  sameLine     out  1   1 = advance not permitted; image gen must repeat line
//  fill         out  BW+1 completed lines from rdCur onward (cur included)
//  ready        out  1   ring primed for this frame
//  ovfl/undfl   out  1   sticky: line dropped / nextLine refused
// BEHAVIOUR
//  Reset: all pointers 0, every bank output 0, rdLine=0, fill=0, sameLine=1, ready=0, flags 0, state SYNC.
//  FSM: SYNC --newFrame rise--> PRIME --fill>=PRIME_LINES--> RUN --newFrame rise--> PRIME.
//    SYNC ignores wrLineDone.
//    newFrame rise in any state: wrPtr=rdPtr=0, fill=0, rdLine=0, ready=0 the next cycle.
//    This is mid-frame resync (in-game reset).
//  Pointers: wrPtr/rdPtr mod NUM_LINES. Banks reserved = prev, cur..cur+fill-1, write bank.
//    Hence full when fill == NUM_LINES-2.
//  wrLineDone, not full: wrPtr++, fill++.
//  wrLineDone, full: wrPtr held (next line overwrites same bank), fill held, ovfl<=1.
//  nextLine accepted iff state RUN and (fill>=2 or rdLine==GBA_LINES-1): rdPtr++, fill--, rdLine++.
//    rdLine wraps from GBA_LINES-1 to 0.
//  nextLine refused: no pointer change, undfl<=1.
//  Simultaneous accepted write + accepted read: both pointers advance, fill unchanged.
//  sameLine = !(RUN && (fill>=2 || rdLine==GBA_LINES-1)); registered, valid 1 cycle after inputs.
//  Window outputs (rdPrev/Cur/NextBank, rdLine) are registered.
//    Update only on the cycle after cacheUpdate, or on PRIME->RUN entry.
//    Otherwise stable, so no mid-line tearing.
//  wrBank updates 1 cycle after wrLineDone.
//  ready asserts 1 cycle after PRIME->RUN; deasserts 1 cycle after newFrame rise.
//  clrFlags wins over a same-cycle set.
// CONFIGURATION
//  LINE_CACHE_STATS_EN defined:
//    adds outputs dropCnt[15:0] (lines dropped) and repeatCnt[15:0] (refused nextLine).
//    Both saturate, clear on clrFlags, reset 0.
//  Undefined: ports absent, no counters; all other behaviour identical.
// STRUCTURE
//  definePackage gains:
//    LC_NUM_LINES, LC_BANK_W, GBA_LINES constants;
//    typedef enum logic [1:0] {LC_SYNC, LC_PRIME, LC_RUN} lcState_t;
//    typedef logic [LC_BANK_W-1:0] lcBank_t.
//  One sub-module: lc_ring_ptr (mod-NUM_LINES pointer with inc and clear), instanced for wr and rd.
// TESTING
//  1 rstN=0 mid-RUN, async -> all outputs at reset values same cycle; state SYNC after release.
//  2 newFrame rise, 2 wrLineDone -> ready=1 one cycle after fill=2; window 0/0/1; wrBank=2.
//  3 steady 160 lines, write/read alternating, plus one same-cycle write+read ->
//    fill stays 1..2, no flags; at line 159 next==cur; rdLine wraps to 0.
//  4 nextLine with fill=1, rdLine=50 -> sameLine=1, rdLine stays 50, undfl=1.
//  5 three wrLineDone without reads (NUM_LINES=4) -> third dropped; wrBank unchanged;
//    ovfl=1; dropCnt=1 if STATS_EN.
//  6 newFrame rise at rdLine=80 -> ready=0, pointers 0, PRIME re-entered; clrFlags clears flags.

Source files
------------

// File: rtl/line_cache_ctrl_pkg.sv
// line_cache_ctrl_pkg: shared constants, types and ring arithmetic for the GBA line-buffer scheduler
package line_cache_ctrl_pkg;
   localparam int LC_NUM_LINES   = 4;
   localparam int LC_BANK_W      = $clog2(LC_NUM_LINES);
   localparam int LC_PRIME_LINES = 2;
   localparam int GBA_LINES      = 160;
   typedef enum logic [1:0] {LC_SYNC, LC_PRIME, LC_RUN} lcState_t;
   typedef logic [LC_BANK_W-1:0] lcBank_t;
   typedef logic [LC_BANK_W:0]   lcFill_t;
   localparam lcFill_t    LC_FULL       = lcFill_t'(LC_NUM_LINES - 2);
   localparam lcFill_t    LC_PRIME_FILL = lcFill_t'(LC_PRIME_LINES);
   localparam lcFill_t    LC_TWO        = lcFill_t'(2);
   localparam logic [7:0] GBA_LAST      = 8'(GBA_LINES - 1);
   function automatic lcBank_t lc_bank_inc(input lcBank_t b);
      return (b == lcBank_t'(LC_NUM_LINES - 1)) ? '0 : b + lcBank_t'(1);
   endfunction
   function automatic lcBank_t lc_bank_dec(input lcBank_t b);
      return (b == '0) ? lcBank_t'(LC_NUM_LINES - 1) : b - lcBank_t'(1);
   endfunction
endpackage

// File: rtl/lc_ring_ptr.sv
// lc_ring_ptr: modulo-LC_NUM_LINES bank pointer with increment and clear
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset, pointer to bank 0
//   clr_i  : return to bank 0 next cycle (wins over inc_i)
//   inc_i  : advance one bank, wrapping at LC_NUM_LINES
//   ptr_o  : registered bank pointer
module lc_ring_ptr
   import line_cache_ctrl_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clr_i,
   input  logic                 inc_i,
   output logic [LC_BANK_W-1:0] ptr_o
);
   lcBank_t ptr_q, ptr_d;
   always_comb ptr_d = clr_i ? '0 : inc_i ? lc_bank_inc(ptr_q) : ptr_q;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) ptr_q <= '0;
      else ptr_q <= ptr_d;
   assign ptr_o = ptr_q;
endmodule

// File: rtl/line_cache_ctrl.sv
// line_cache_ctrl: schedules the GBA line-buffer ring between capture (writer) and HDMI image gen (reader)
//   pxl_clk_i      : pixel clock
//   rst_n_i        : asynchronous active-low reset
//   new_frame_i    : GBA frame start level; rising edge resyncs the ring
//   wr_line_done_i : capture finished writing bank wr_bank_o
//   next_line_i    : image gen asks to advance one GBA line
//   cache_update_i : latch a new read window (end of visible line)
//   clr_flags_i    : clear sticky flags (and stats counters)
//   wr_bank_o      : bank capture writes into
//   rd_prev/cur/next_bank_o : banks of lines rd_line_o-1 / rd_line_o / rd_line_o+1, clamped at frame edges
//   rd_line_o      : GBA line shown in the current window
//   same_line_o    : advance not permitted, image gen must repeat the line
//   fill_o         : completed lines from the current read bank onward
//   ready_o        : ring primed for this frame
//   ovfl_o/undfl_o : sticky line-dropped / nextLine-refused
//   drop_cnt_o, repeat_cnt_o : saturating event counters, present only with LINE_CACHE_STATS_EN
module line_cache_ctrl
   import line_cache_ctrl_pkg::*;
(
   input  logic                 pxl_clk_i,
   input  logic                 rst_n_i,
   input  logic                 new_frame_i,
   input  logic                 wr_line_done_i,
   input  logic                 next_line_i,
   input  logic                 cache_update_i,
   input  logic                 clr_flags_i,
   output logic [LC_BANK_W-1:0] wr_bank_o,
   output logic [LC_BANK_W-1:0] rd_prev_bank_o,
   output logic [LC_BANK_W-1:0] rd_cur_bank_o,
   output logic [LC_BANK_W-1:0] rd_next_bank_o,
   output logic [7:0]           rd_line_o,
   output logic                 same_line_o,
   output logic [LC_BANK_W:0]   fill_o,
   output logic                 ready_o,
   output logic                 ovfl_o,
`ifdef LINE_CACHE_STATS_EN
   output logic                 undfl_o,
   output logic [15:0]          drop_cnt_o,
   output logic [15:0]          repeat_cnt_o
`else
   output logic                 undfl_o
`endif
);
   lcState_t   state_q, state_d;
   lcFill_t    fill_q, fill_d;
   logic [7:0] line_q, line_d, rd_line_q, rd_line_d;
   lcBank_t    wr_ptr, rd_ptr, rd_nxt, prev_q, prev_d, cur_q, cur_d, next_q, next_d;
   logic       nf_q, rise, can_adv, rd_acc, rd_ref, wr_req, full, wr_acc, wr_drop, win_ld;
   logic       same_q, same_d, ready_q, ready_d, ovfl_q, ovfl_d, undfl_q, undfl_d;

   lc_ring_ptr u_wr_ptr (.clk_i(pxl_clk_i), .rst_ni(rst_n_i), .clr_i(rise), .inc_i(wr_acc), .ptr_o(wr_ptr));
   lc_ring_ptr u_rd_ptr (.clk_i(pxl_clk_i), .rst_ni(rst_n_i), .clr_i(rise), .inc_i(rd_acc), .ptr_o(rd_ptr));

   // line_q tracks the line at rd_ptr; rd_line_q is the published copy that only moves with the window.
   // A read accepted in the same cycle frees the oldest bank, so a write that cycle is not a drop.
   always_comb begin
      rise      = new_frame_i & ~nf_q;
      can_adv   = (state_q == LC_RUN) && (fill_q >= LC_TWO || line_q == GBA_LAST);
      rd_acc    = next_line_i & can_adv & ~rise;
      rd_ref    = next_line_i & ~can_adv;
      wr_req    = wr_line_done_i & (state_q != LC_SYNC) & ~rise;
      full      = (fill_q == LC_FULL) & ~rd_acc;
      wr_acc    = wr_req & ~full;
      wr_drop   = wr_req & full;
      fill_d    = rise ? '0 : fill_q + lcFill_t'(wr_acc) - lcFill_t'(rd_acc && fill_q != '0);
      line_d    = rise ? '0 : !rd_acc ? line_q : (line_q == GBA_LAST) ? '0 : line_q + 8'd1;
      rd_nxt    = rd_acc ? lc_bank_inc(rd_ptr) : rd_ptr;
      state_d   = rise ? LC_PRIME : (state_q == LC_PRIME && fill_d >= LC_PRIME_FILL) ? LC_RUN : state_q;
      win_ld    = cache_update_i | (state_q == LC_PRIME && state_d == LC_RUN);
      cur_d     = rise ? '0 : win_ld ? rd_nxt : cur_q;
      prev_d    = rise ? '0 : !win_ld ? prev_q : (line_d == '0) ? rd_nxt : lc_bank_dec(rd_nxt);
      next_d    = rise ? '0 : !win_ld ? next_q : (line_d == GBA_LAST) ? rd_nxt : lc_bank_inc(rd_nxt);
      rd_line_d = rise ? '0 : win_ld ? line_d : rd_line_q;
      same_d    = !(state_d == LC_RUN && (fill_d >= LC_TWO || line_d == GBA_LAST));
      ready_d   = (state_q == LC_RUN) & ~rise;
      ovfl_d    = ~clr_flags_i & (ovfl_q | wr_drop);
      undfl_d   = ~clr_flags_i & (undfl_q | rd_ref);
   end

   always_ff @(posedge pxl_clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         state_q   <= LC_SYNC;
         nf_q      <= 1'b0;
         fill_q    <= '0;
         line_q    <= '0;
         rd_line_q <= '0;
         prev_q    <= '0;
         cur_q     <= '0;
         next_q    <= '0;
         same_q    <= 1'b1;
         ready_q   <= 1'b0;
         ovfl_q    <= 1'b0;
         undfl_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         nf_q      <= new_frame_i;
         fill_q    <= fill_d;
         line_q    <= line_d;
         rd_line_q <= rd_line_d;
         prev_q    <= prev_d;
         cur_q     <= cur_d;
         next_q    <= next_d;
         same_q    <= same_d;
         ready_q   <= ready_d;
         ovfl_q    <= ovfl_d;
         undfl_q   <= undfl_d;
      end

`ifdef LINE_CACHE_STATS_EN
   logic [15:0] drop_cnt_q, drop_cnt_d, repeat_cnt_q, repeat_cnt_d;
   always_comb begin
      drop_cnt_d   = clr_flags_i ? '0 : (wr_drop && drop_cnt_q != '1) ? drop_cnt_q + 16'd1 : drop_cnt_q;
      repeat_cnt_d = clr_flags_i ? '0 : (rd_ref && repeat_cnt_q != '1) ? repeat_cnt_q + 16'd1 : repeat_cnt_q;
   end
   always_ff @(posedge pxl_clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         drop_cnt_q   <= '0;
         repeat_cnt_q <= '0;
      end else begin
         drop_cnt_q   <= drop_cnt_d;
         repeat_cnt_q <= repeat_cnt_d;
      end
   assign drop_cnt_o   = drop_cnt_q;
   assign repeat_cnt_o = repeat_cnt_q;
`endif

   assign wr_bank_o      = wr_ptr;
   assign rd_prev_bank_o = prev_q;
   assign rd_cur_bank_o  = cur_q;
   assign rd_next_bank_o = next_q;
   assign rd_line_o      = rd_line_q;
   assign same_line_o    = same_q;
   assign fill_o         = fill_q;
   assign ready_o        = ready_q;
   assign ovfl_o         = ovfl_q;
   assign undfl_o        = undfl_q;
endmodule

// File: tb/tb_line_cache_ctrl.sv
// tb_line_cache_ctrl: directed self-checking bench for line_cache_ctrl (LINE_CACHE_STATS_EN optional)
module tb_line_cache_ctrl;
   import line_cache_ctrl_pkg::*;
   logic clk = 0, rst_n = 0, new_frame = 0, wr_done = 0, next_line = 0, cache_upd = 0, clr_flags = 0;
   logic [LC_BANK_W-1:0] wr_bank, rd_prev, rd_cur, rd_next;
   logic [7:0] rd_line;
   logic [LC_BANK_W:0] fill;
   logic same_line, ready, ovfl, undfl;
`ifdef LINE_CACHE_STATS_EN
   logic [15:0] drop_cnt, repeat_cnt;
`endif
   int n_chk = 0, n_fail = 0, bad = 0;

   always #5 clk = ~clk;

   line_cache_ctrl dut (
      .pxl_clk_i(clk), .rst_n_i(rst_n), .new_frame_i(new_frame), .wr_line_done_i(wr_done),
      .next_line_i(next_line), .cache_update_i(cache_upd), .clr_flags_i(clr_flags),
      .wr_bank_o(wr_bank), .rd_prev_bank_o(rd_prev), .rd_cur_bank_o(rd_cur), .rd_next_bank_o(rd_next),
      .rd_line_o(rd_line), .same_line_o(same_line), .fill_o(fill), .ready_o(ready),
      .ovfl_o(ovfl),
`ifdef LINE_CACHE_STATS_EN
      .undfl_o(undfl), .drop_cnt_o(drop_cnt), .repeat_cnt_o(repeat_cnt)
`else
      .undfl_o(undfl)
`endif
   );

   task automatic chk(input string tag, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, req);
      end
   endtask

   // called at a negedge; drives for one posedge, returns at the following negedge
   task automatic cyc(input logic wr, input logic nl, input logic cu, input logic cl);
      wr_done = wr; next_line = nl; cache_upd = cu; clr_flags = cl;
      @(negedge clk);
      wr_done = 0; next_line = 0; cache_upd = 0; clr_flags = 0;
   endtask

   task automatic chk_win(input string tag, input int p, input int c, input int n, input int l);
      chk({tag, "_prev"}, rd_prev, p);
      chk({tag, "_cur"}, rd_cur, c);
      chk({tag, "_next"}, rd_next, n);
      chk({tag, "_line"}, rd_line, l);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("rst_wrbank", wr_bank, 0);
      chk_win("rst", 0, 0, 0, 0);
      chk("rst_same", same_line, 1);
      chk("rst_fill", fill, 0);
      chk("rst_ready", ready, 0);
      chk("rst_ovfl", ovfl, 0);
      chk("rst_undfl", undfl, 0);
      cyc(1, 0, 0, 0);
      chk("sync_fill", fill, 0);
      chk("sync_wrbank", wr_bank, 0);

      new_frame = 1;
      @(negedge clk);
      chk("prime_ready", ready, 0);
      cyc(1, 0, 0, 0);
      chk("prime_fill1", fill, 1);
      chk("prime_wrbank1", wr_bank, 1);
      cyc(1, 0, 0, 0);
      chk("prime_fill2", fill, 2);
      chk("prime_wrbank2", wr_bank, 2);
      chk("prime_ready_early", ready, 0);
      chk("prime_same", same_line, 0);
      chk_win("prime", 0, 0, 1, 0);
      @(negedge clk);
      chk("run_ready", ready, 1);

      cyc(1, 0, 0, 0);
      chk("drop_fill", fill, 2);
      chk("drop_wrbank", wr_bank, 2);
      chk("drop_ovfl", ovfl, 1);
`ifdef LINE_CACHE_STATS_EN
      chk("drop_cnt", drop_cnt, 1);
`endif
      cyc(0, 0, 0, 1);
      chk("clr_ovfl", ovfl, 0);
`ifdef LINE_CACHE_STATS_EN
      chk("clr_drop_cnt", drop_cnt, 0);
`endif

      for (int i = 0; i < 159; i++) begin
         if (i == 10) begin
            cyc(1, 1, 0, 0);
            chk("simul_fill", fill, 2);
            chk("simul_wrbank", wr_bank, 1);
         end else begin
            cyc(0, 1, 0, 0);
            if (i == 49) begin
               cyc(0, 0, 1, 0);
               cyc(0, 1, 0, 0);
               chk("refuse_same", same_line, 1);
               chk("refuse_line", rd_line, 50);
               chk("refuse_fill", fill, 1);
               chk("refuse_undfl", undfl, 1);
`ifdef LINE_CACHE_STATS_EN
               chk("refuse_repeat_cnt", repeat_cnt, 1);
`endif
               cyc(0, 0, 0, 1);
               chk("refuse_clr", undfl, 0);
            end
            if (i != 158) cyc(1, 0, 0, 0);
         end
         cyc(0, 0, 1, 0);
         if (fill < 1 || fill > 2 || ovfl || undfl || rd_line != 8'(i + 1)) bad++;
      end
      chk("steady_bad", bad, 0);
      chk_win("last", 2, 3, 3, 159);
      chk("last_fill", fill, 1);
      chk("last_same", same_line, 0);
      chk("last_wrbank", wr_bank, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 0);
      chk_win("wrap", 0, 0, 1, 0);
      chk("wrap_fill", fill, 0);
      chk("wrap_same", same_line, 1);
      chk("wrap_undfl", undfl, 0);

      new_frame = 0;
      @(negedge clk);
      new_frame = 1;
      @(negedge clk);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 80; i++) begin
         cyc(0, 1, 0, 0);
         cyc(1, 0, 0, 0);
      end
      cyc(0, 0, 1, 0);
      chk_win("l80", 3, 0, 1, 80);
      chk("l80_wrbank", wr_bank, 2);
      cyc(1, 0, 0, 0);
      chk("l80_ovfl", ovfl, 1);
      new_frame = 0;
      @(negedge clk);
      new_frame = 1;
      @(negedge clk);
      chk("resync_ready", ready, 0);
      chk("resync_fill", fill, 0);
      chk("resync_wrbank", wr_bank, 0);
      chk("resync_same", same_line, 1);
      chk_win("resync", 0, 0, 0, 0);
      chk("resync_ovfl_sticky", ovfl, 1);
      cyc(0, 0, 0, 1);
      chk("resync_clr", ovfl, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      @(negedge clk);
      chk("reprime_ready", ready, 1);
      chk_win("reprime", 0, 0, 1, 0);

      #2 rst_n = 0;
      new_frame = 0;
      #1;
      chk("arst_fill", fill, 0);
      chk("arst_ready", ready, 0);
      chk("arst_same", same_line, 1);
      chk("arst_wrbank", wr_bank, 0);
      chk("arst_next", rd_next, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      cyc(1, 0, 0, 0);
      chk("arst_sync_fill", fill, 0);
      chk("arst_sync_wrbank", wr_bank, 0);
      chk("arst_sync_ready", ready, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
